// File: rtl/operand_fetch.sv
// Operand-fetch stage: register file + busy scoreboard feeding the ALU from one output register.
// Latency: 1 cycle from accept to out_valid; one instruction per cycle when the ALU keeps up.
// Backpressure: in_ready drops on RAW/WAW hazard or when the held output is not consumed.
// Optional forwarding from the write-back port: define OPERAND_FETCH_BYPASS_EN.

package typedefs_pkg;
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SRA = 3'd7
  } aluop_sel_t;
endpackage

module operand_fetch
  import typedefs_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int NREGS  = 8,
  localparam int AWIDTH = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AWIDTH-1:0] in_rs1,
  input  logic [AWIDTH-1:0] in_rs2,
  input  logic [AWIDTH-1:0] in_rd,
  input  logic              in_rd_we,
  input  logic              in_use_imm,
  input  logic [DWIDTH-1:0] in_imm,
  input  aluop_sel_t        in_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_src1,
  output logic [DWIDTH-1:0] out_src2,
  output aluop_sel_t        out_sel,
  output logic [AWIDTH-1:0] out_rd,
  output logic              out_rd_we,
  input  logic              wb_valid,
  input  logic [AWIDTH-1:0] wb_rd,
  input  logic [DWIDTH-1:0] wb_data
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [DWIDTH-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [DWIDTH-1:0] src1_q, src2_q;
  aluop_sel_t        sel_q;
  logic [AWIDTH-1:0] rd_q;
  logic              rd_we_q;

  logic              fwd1, fwd2, fwdd;
  logic              haz1, haz2, hazd, hazard;
  logic [DWIDTH-1:0] opnd1, opnd2;
  logic              accept;

  // Forwarding match: a write-back landing on a source/destination this cycle.
  always_comb begin
    fwd1 = 1'b0;
    fwd2 = 1'b0;
    fwdd = 1'b0;
`ifdef OPERAND_FETCH_BYPASS_EN
    fwd1 = wb_valid && (wb_rd == in_rs1) && (in_rs1 != '0);
    fwd2 = wb_valid && (wb_rd == in_rs2) && (in_rs2 != '0);
    fwdd = wb_valid && (wb_rd == in_rd)  && (in_rd  != '0);
`endif
  end

  // Hazard detection and operand selection; reg 0 always reads as zero.
  always_comb begin
    haz1   = (in_rs1 != '0) && busy_q[in_rs1] && !fwd1;
    haz2   = !in_use_imm && (in_rs2 != '0) && busy_q[in_rs2] && !fwd2;
    hazd   = in_rd_we && (in_rd != '0) && busy_q[in_rd] && !fwdd;
    hazard = haz1 || haz2 || hazd;
    opnd1  = (in_rs1 == '0) ? '0 : (fwd1 ? wb_data : regs_q[in_rs1]);
    if (in_use_imm) begin
      opnd2 = in_imm;
    end else begin
      opnd2 = (in_rs2 == '0) ? '0 : (fwd2 ? wb_data : regs_q[in_rs2]);
    end
    in_ready = !hazard && ((state_q == EMPTY) || out_ready);
    accept   = in_valid && in_ready;
  end

  // Output-register occupancy: loads on accept, drains when consumed with nothing behind it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (out_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Busy bits: write-back clears, accept with a destination sets; set wins on a tie.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_rd] = 1'b0;
    if (accept && in_rd_we && (in_rd != '0)) busy_d[in_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Busy scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // Register file write port; writes to reg 0 are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wb_valid && (wb_rd != '0)) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  // Output operand register; held while the ALU is not consuming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src1_q  <= '0;
      src2_q  <= '0;
      sel_q   <= ALU_ADD;
      rd_q    <= '0;
      rd_we_q <= 1'b0;
    end else if (accept) begin
      src1_q  <= opnd1;
      src2_q  <= opnd2;
      sel_q   <= in_sel;
      rd_q    <= in_rd;
      rd_we_q <= in_rd_we;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_src1  = src1_q;
  assign out_src2  = src2_q;
  assign out_sel   = sel_q;
  assign out_rd    = rd_q;
  assign out_rd_we = rd_we_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Randomized and directed bench for operand_fetch with a queue scoreboard.
// Expected operands come from an architectural register/busy model updated per cycle.
// A negedge monitor compares every presented output against the queue head.

module tb_operand_fetch;
  import typedefs_pkg::*;

  localparam int DW = 8;
  localparam int NR = 8;
  localparam int AW = 3;

  logic          clk, rst_n;
  logic          in_valid, in_ready, in_rd_we, in_use_imm;
  logic [AW-1:0] in_rs1, in_rs2, in_rd;
  logic [DW-1:0] in_imm;
  aluop_sel_t    in_sel, out_sel;
  logic          out_valid, out_ready, out_rd_we;
  logic [DW-1:0] out_src1, out_src2;
  logic [AW-1:0] out_rd;
  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;

  operand_fetch #(.DWIDTH(DW), .NREGS(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .in_use_imm(in_use_imm), .in_imm(in_imm), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_src1(out_src1), .out_src2(out_src2), .out_sel(out_sel),
    .out_rd(out_rd), .out_rd_we(out_rd_we),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] src1;
    logic [DW-1:0] src2;
    aluop_sel_t    sel;
    logic [AW-1:0] rd;
    logic          rd_we;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] m_regs [NR];
  bit            m_busy [NR];
  bit            bypass;

  initial begin
`ifdef OPERAND_FETCH_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model: a write-back this cycle forwards only when bypass is built in.
  function automatic bit m_fwd(input int r);
    return bypass && wb_valid && (int'(wb_rd) == r) && (r != 0);
  endfunction

  function automatic bit m_stall(input int r);
    return (r != 0) && m_busy[r] && !m_fwd(r);
  endfunction

  function automatic logic [DW-1:0] m_read(input int r);
    if (r == 0) return '0;
    if (m_fwd(r)) return wb_data;
    return m_regs[r];
  endfunction

  task automatic m_reset();
    sb.delete();
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // One cycle of stimulus; called just after a rising edge, returns at the next one.
  task automatic step(input bit v, input int rs1, input int rs2, input int rd, input bit we,
                      input bit imm_en, input logic [DW-1:0] imm, input aluop_sel_t sel,
                      input bit ordy, input bit wbv, input int wbrd, input logic [DW-1:0] wbd);
    bit   exp_ready;
    exp_t e;
    #1;
    in_valid = v; in_rs1 = AW'(rs1); in_rs2 = AW'(rs2); in_rd = AW'(rd);
    in_rd_we = we; in_use_imm = imm_en; in_imm = imm; in_sel = sel;
    out_ready = ordy; wb_valid = wbv; wb_rd = AW'(wbrd); wb_data = wbd;
    #2;
    exp_ready = !(m_stall(rs1) || (!imm_en && m_stall(rs2)) || (we && m_stall(rd)))
                && (sb.size() == 0 || ordy);
    check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    check("in_ready", 64'(in_ready), 64'(exp_ready));
    if (v && exp_ready) begin
      e.src1  = m_read(rs1);
      e.src2  = imm_en ? imm : m_read(rs2);
      e.sel   = sel;
      e.rd    = AW'(rd);
      e.rd_we = we;
      sb.push_back(e);
    end
    if (wbv && wbrd != 0) begin
      m_regs[wbrd] = wbd;
      m_busy[wbrd] = 1'b0;
    end
    if (v && exp_ready && we && rd != 0) m_busy[rd] = 1'b1;
    @(posedge clk);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, '0, ALU_ADD, 1, 0, 0, '0);
  endtask

  task automatic wbt(input int r, input logic [DW-1:0] d);
    step(0, 0, 0, 0, 0, 0, '0, ALU_ADD, 1, 1, r, d);
  endtask

  task automatic issue(input int rs1, input int rs2, input int rd, input bit we,
                       input bit imm_en, input logic [DW-1:0] imm, input aluop_sel_t sel);
    step(1, rs1, rs2, rd, we, imm_en, imm, sel, 1, 0, 0, '0);
  endtask

  // Monitor: every presented output must match the oldest outstanding expectation.
  always begin
    @(negedge clk);
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out actual=valid expected=idle at %0t", $time);
      end else begin
        check("out_data", 64'({out_src1, out_src2, out_sel, out_rd, out_rd_we}), 64'(sb[0]));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int   busy_list[$];
    int   r;
    logic [DW-1:0] d;
    m_reset();
    rst_n = 1'b0; in_valid = 0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rd_we = 0;
    in_use_imm = 0; in_imm = '0; in_sel = ALU_ADD; out_ready = 0;
    wb_valid = 0; wb_rd = '0; wb_data = '0;
    #3;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_regs", 64'({out_src1, out_src2, out_rd, out_rd_we}), 64'(0));
    check("rst_out_sel", 64'(out_sel), 64'(ALU_ADD));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    // Basic read of two written registers.
    wbt(3, 8'h2A);
    wbt(4, 8'h05);
    issue(3, 4, 0, 0, 0, '0, ALU_ADD);
    nop(1);

    // Register 0: immediate operand, rd=0 never becomes busy, writes to r0 are dropped.
    issue(0, 0, 0, 1, 1, 8'h7F, ALU_OR);
    issue(0, 0, 0, 1, 1, 8'h01, ALU_XOR);
    wbt(0, 8'hFF);
    issue(0, 0, 1, 0, 0, '0, ALU_SUB);
    nop(1);

    // RAW: rs1=5 waits for the write-back of r5.
    issue(0, 0, 5, 1, 1, 8'h10, ALU_ADD);
    issue(5, 0, 6, 0, 1, 8'h01, ALU_ADD);
    issue(5, 0, 6, 0, 1, 8'h01, ALU_ADD);
    step(1, 5, 0, 6, 0, 1, 8'h01, ALU_ADD, 1, 1, 5, 8'h11);
    issue(5, 0, 6, 0, 1, 8'h02, ALU_SUB);
    nop(1);

    // Backpressure: output held for two cycles, then drained and reloaded on one edge.
    issue(3, 4, 7, 0, 0, '0, ALU_AND);
    step(1, 4, 3, 1, 0, 0, '0, ALU_SLL, 0, 0, 0, '0);
    step(1, 4, 3, 1, 0, 0, '0, ALU_SLL, 0, 0, 0, '0);
    step(1, 4, 3, 1, 0, 0, '0, ALU_SLL, 1, 0, 0, '0);
    nop(1);

    // WAW on r2, including a write-back to a register that is not busy.
    wbt(6, 8'h66);
    issue(1, 1, 2, 1, 0, '0, ALU_ADD);
    issue(1, 1, 2, 1, 0, '0, ALU_SUB);
    issue(1, 1, 2, 1, 0, '0, ALU_SUB);
    step(1, 1, 1, 2, 1, 0, '0, ALU_SUB, 1, 1, 2, 8'h22);
    issue(1, 1, 2, 1, 0, '0, ALU_SRA);
    wbt(2, 8'h23);
    nop(1);

    // Asynchronous reset while an instruction is held and r5 is busy.
    issue(0, 0, 5, 1, 1, 8'h33, ALU_ADD);
    step(0, 0, 0, 0, 0, 0, '0, ALU_ADD, 0, 0, 0, '0);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'(0));
    check("arst_out_regs", 64'({out_src1, out_src2, out_rd, out_rd_we}), 64'(0));
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    issue(5, 3, 5, 1, 0, '0, ALU_ADD);
    issue(4, 6, 0, 0, 0, '0, ALU_XOR);
    nop(1);
    wbt(5, 8'h01);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      bit wbv;
      wbv = ($urandom_range(0, 1) == 1);
      busy_list.delete();
      for (int i = 1; i < NR; i++) if (m_busy[i]) busy_list.push_back(i);
      if (busy_list.size() != 0 && $urandom_range(0, 3) != 0)
        r = busy_list[$urandom_range(0, busy_list.size() - 1)];
      else
        r = $urandom_range(0, NR - 1);
      d = DW'($urandom);
      step($urandom_range(0, 3) != 0, $urandom_range(0, NR - 1), $urandom_range(0, NR - 1),
           $urandom_range(0, NR - 1), $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
           DW'($urandom), aluop_sel_t'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
           wbv, r, d);
    end

    nop(4);
    check("drain_empty", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
